// File: rtl/deadlock_idx_monitor_core_if.sv
// Blocked/idle status vectors into a per-kernel deadlock monitor,
// plus the monitor's verdict and snapshot outputs.
interface deadlock_idx_monitor_core_if #(
  parameter int N_AXIS = 15,
  parameter int N_INST = 2,
  parameter int N_BLK  = 1,
  parameter int CNT_W  = 16
);
  localparam int IDX_W = (N_AXIS > 1) ? $clog2(N_AXIS) : 1;

  logic [N_AXIS-1:0] axis_block_sigs;
  logic [N_INST-1:0] inst_idle_sigs;
  logic [N_BLK-1:0]  inst_block_sigs;
  logic              block;
  logic [N_AXIS-1:0] block_axis_snap;
  logic [IDX_W-1:0]  block_first_idx;
  logic              block_any_inst;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output axis_block_sigs,
    output inst_idle_sigs,
    output inst_block_sigs,
    input  block,
    input  block_axis_snap,
    input  block_first_idx,
    input  block_any_inst,
    input  stall_count
  );

  modport slave (
    input  axis_block_sigs,
    input  inst_idle_sigs,
    input  inst_block_sigs,
    output block,
    output block_axis_snap,
    output block_first_idx,
    output block_any_inst,
    output stall_count
  );
endinterface

// File: rtl/deadlock_idx_monitor_core.sv
// Per-kernel deadlock detector: flags a non-idle kernel whose blocking
// pattern stays frozen for THRESHOLD cycles and snapshots the culprits.
module deadlock_idx_monitor_core #(
  parameter int N_AXIS    = 15,
  parameter int N_INST    = 2,
  parameter int N_BLK     = 1,
  parameter int THRESHOLD = 1000,
  parameter int CNT_W     = 16
) (
  input logic clock,
  input logic reset,
  deadlock_idx_monitor_core_if.slave mon
);
  localparam int IDX_W = (N_AXIS > 1) ? $clog2(N_AXIS) : 1;
  localparam int PAT_W = N_BLK + N_AXIS;
  localparam logic [CNT_W-1:0] THR_C  = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(THRESHOLD - 1);

  if (CNT_W < $clog2(THRESHOLD + 1)) begin : g_cnt_w_chk
    $error("CNT_W too narrow to hold THRESHOLD");
  end

  typedef enum logic [1:0] {
    MONITOR,
    SUSPECT,
    DEADLOCK
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PAT_W-1:0]  prev_q;
  logic [N_AXIS-1:0] snap_q;
  logic [IDX_W-1:0]  idx_q;
  logic              any_q;

  logic              stalled;
  logic              same;
  logic              capture;
  logic [PAT_W-1:0]  pattern;
  logic [IDX_W-1:0]  first_idx;

  assign pattern = {mon.inst_block_sigs, mon.axis_block_sigs};
  assign same    = (pattern == prev_q);
  // Fully idle kernel with stale block bits is quiescent, not stuck.
  assign stalled = ((|mon.axis_block_sigs) | (|mon.inst_block_sigs))
                 & ~(&mon.inst_idle_sigs);

  always_comb begin
    first_idx = '0;
    for (int i = N_AXIS - 1; i >= 0; i--) begin
      if (mon.axis_block_sigs[i]) first_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      MONITOR: begin
        if (stalled) begin
          state_d = SUSPECT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      SUSPECT: begin
        if (!stalled) begin
          state_d = MONITOR;
          cnt_d   = '0;
        end else if (!same) begin
          cnt_d   = CNT_W'(1);
        end else if (cnt_q >= LAST_C) begin
          state_d = DEADLOCK;
          cnt_d   = THR_C;
          capture = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      DEADLOCK: begin
        cnt_d = THR_C;
      end
      default: begin
        state_d = MONITOR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= MONITOR;
      cnt_q   <= '0;
      prev_q  <= '0;
      snap_q  <= '0;
      idx_q   <= '0;
      any_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= pattern;
      if (capture) begin
        snap_q <= mon.axis_block_sigs;
        idx_q  <= first_idx;
        any_q  <= |mon.inst_block_sigs;
      end
    end
  end

  assign mon.block           = (state_q == DEADLOCK);
  assign mon.block_axis_snap = snap_q;
  assign mon.block_first_idx = idx_q;
  assign mon.block_any_inst  = any_q;
  assign mon.stall_count     = cnt_q;
endmodule
